lsu_align: RTL and testbench
============================

# lsu_align

Load/store alignment unit between the single-cycle datapath and the word-addressed data memory. Translates RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into whole-word memory accesses. Loads are lane-selected and sign- or zero-extended combinationally. Byte and halfword stores run as a two-cycle read-modify-write that stalls the core for one cycle, because the data memory can only write whole 32-bit words.

## Interface
Parameters:
- none; data and address widths are fixed at 32 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  load or store instruction present this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  funct3[1:0]: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  in  1  funct3[2]; for loads, 1 = zero-extend.
- req_addr  in  32  byte address from the ALU.
- req_wdata  in  32  store data (rs2); the low byte or low half is used for sub-word stores.
- rdata  out  32  extended load result to the writeback mux.
- stall  out  1  core holds PC and the current request while this is 1.
- misaligned  out  1  current request is misaligned or has reserved size (combinational).
- err_sticky  out  1  set by any flagged request; cleared only by reset.
- mem_a  out  32  word address to memory: {addr[31:2], 2'b00}.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory combinational read data.

## Operation
- Two states: IDLE and RMW. Reset puts the block in IDLE.
- Loads, IDLE, any size:
  - mem_a = {req_addr[31:2], 2'b00}; mem_we = 0; stall = 0.
  - Byte lane = req_addr[1:0]; half lane = req_addr[1].
  - rdata is the selected lane, sign-extended, or zero-extended when req_unsigned = 1.
- Word store, IDLE: mem_we = 1 and mem_wd = req_wdata in the same cycle; stall = 0; stays in IDLE.
- Byte or half store, IDLE:
  - stall = 1; mem_we = 0.
  - Registers the word address, size, lane and new data, plus merge_q = mem_rd (the old word).
  - Next state: RMW.
- RMW:
  - mem_a = latched address; mem_we = 1.
  - mem_wd = merge_q with the target byte or half replaced by the latched data.
  - stall = 0; req_* inputs are ignored; next state: IDLE.
- When req_valid = 0, mem_we = 0, stall = 0 and the block stays in IDLE.
- rdata always reflects the current req_* and mem_rd. It is only meaningful for valid loads.

## Timing
- Load latency: 0 extra cycles; rdata is combinational.
- Word store: 0 extra cycles.
- Sub-word store: exactly 1 stall cycle; the memory write lands on the second rising edge.
- Handshake:
  - The core must keep req_* stable while stall = 1.
  - The PC advances on the edge that ends the RMW cycle.
  - A new request is accepted only in IDLE.
- Reset:
  - While reset = 1: mem_we = 0, stall = 0, and the next state is IDLE.
  - A reset asserted in RMW cancels the write; memory is unchanged.
  - After reset: err_sticky = 0; merge_q = 0 (not observable).
- The address is never incremented, so no wrap-around occurs.
- Back-to-back sub-word stores each take 2 cycles with no bubble between them.

## Configuration
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined:
  - A half access with addr[0] = 1, a word access with addr[1:0] != 0, or any req_size = 11 raises misaligned combinationally.
  - err_sticky is set on the next edge.
  - A flagged store never writes (mem_we = 0, no RMW).
  - A flagged load returns rdata = 0.
- Not defined:
  - misaligned and err_sticky are tied to 0.
  - Half accesses use lane addr[1] and ignore addr[0].
  - Word accesses ignore addr[1:0].
  - req_size = 11 is treated as word.

## Test plan
- Load extension: mem_rd = 0x8081_F27F, addr = 0x11.
  - LB -> rdata = 0xFFFF_FFF2.
  - LBU -> rdata = 0x0000_00F2.
  - LH at 0x12 -> 0xFFFF_8081.
  - LHU at 0x12 -> 0x0000_8081.
- SW at 0x20 with wdata 0xDEAD_BEEF -> mem_we = 1 in the same cycle, mem_wd = 0xDEAD_BEEF, stall never asserted.
- SB: old word 0x1122_3344, addr 0x22, wdata 0xAB.
  - Cycle 1: stall = 1, mem_we = 0.
  - Cycle 2: mem_we = 1, mem_wd = 0x11AB_3344, stall = 0.
- SH at 0x24 then SB at 0x27 back-to-back -> 4 cycles total, stall pattern 1,0,1,0, both merges correct.
- Reset asserted during RMW of an SB -> mem_we = 0 on that edge, state IDLE, memory word unchanged.
- Misalignment, with LSU_MISALIGN_CHECK_EN:
  - SW at 0x22 -> misaligned = 1, mem_we = 0, err_sticky = 1 on the next edge and held until reset.
  - Without the macro, the same SW writes the word at address 0x20.

Source files
------------

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//
// Load/store alignment unit sitting between the single-cycle datapath and a
// word-addressed data memory that can only write whole 32-bit words.
//
//   * Loads (LB/LH/LW/LBU/LHU): one combinational cycle. The word at
//     {req_addr[31:2], 2'b00} is read, the addressed byte or half is selected
//     and sign- or zero-extended onto rdata.
//   * Word stores (SW): written straight through in the same cycle.
//   * Byte/half stores (SB/SH): two-cycle read-modify-write. Cycle 1 (IDLE)
//     captures the old word from mem_rd and raises stall. Cycle 2 (RMW) writes
//     the merged word back. The core holds req_* stable while stall = 1.
//
// Handshake: req_valid qualifies a request in IDLE only. stall = 1 means the
// core must hold the PC and every req_* input for one more cycle. The request
// retires on the rising edge where stall = 0. In RMW, req_* is ignored.
//
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses and req_size = 2'b11 are flagged.
//               Flagged stores do not write. Flagged loads return 0.
//               err_sticky latches the flag until reset.
//   undefined : misaligned and err_sticky are tied to 0.
//               Half accesses use lane addr[1]. Word accesses ignore addr[1:0].
//               req_size = 2'b11 behaves as a word access.
//
// Ports
//   clk, reset     : clock and synchronous active-high reset
//   req_valid      : load/store present this cycle
//   req_we         : 1 = store, 0 = load
//   req_size       : funct3[1:0] (00 byte, 01 half, 10 word, 11 reserved)
//   req_unsigned   : funct3[2], zero-extend loads when 1
//   req_addr       : byte address
//   req_wdata      : store data (low byte/half used for sub-word stores)
//   rdata          : extended load data
//   stall          : hold the core for one cycle (first cycle of SB/SH)
//   misaligned     : current request flagged (combinational)
//   err_sticky     : any flagged request seen since reset
//   mem_a          : word-aligned memory address
//   mem_we, mem_wd : memory write enable and write data
//   mem_rd         : combinational memory read data
//   dbg_state      : 1 while the FSM is in the RMW state
// -----------------------------------------------------------------------------
module lsu_align (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        err_sticky,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RMW  = 1'b1
  } state_t;

  state_t      state;

  // Latched sub-word store, captured in the IDLE cycle of SB/SH.
  logic [31:0] addr_q;   // word address
  logic [31:0] merge_q;  // old memory word
  logic [15:0] data_q;   // new byte/half (low bits of req_wdata)
  logic [1:0]  lane_q;   // byte lane; lane_q[1] selects the half
  logic        half_q;   // 1 = half store, 0 = byte store

  logic        start_rmw;
  logic [31:0] merged;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign dbg_state = (state == S_RMW);

  // ---------------------------------------------------------------------------
  // Misalignment detection
  // ---------------------------------------------------------------------------
`ifdef LSU_MISALIGN_CHECK_EN
  logic mis_raw;

  always_comb begin
    mis_raw = 1'b0;
    case (req_size)
      2'b01:   mis_raw = req_addr[0];
      2'b10:   mis_raw = |req_addr[1:0];
      2'b11:   mis_raw = 1'b1;          // reserved size
      default: mis_raw = 1'b0;
    endcase
  end

  assign misaligned = req_valid & mis_raw;
`else
  assign misaligned = 1'b0;
  assign err_sticky = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Load path: lane select and extension, purely combinational
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_lane = 8'h00;
    case (req_addr[1:0])
      2'd0:    byte_lane = mem_rd[7:0];
      2'd1:    byte_lane = mem_rd[15:8];
      2'd2:    byte_lane = mem_rd[23:16];
      default: byte_lane = mem_rd[31:24];
    endcase

    // addr[0] is ignored for halves; misaligned halves are flagged separately.
    half_lane = req_addr[1] ? mem_rd[31:16] : mem_rd[15:0];

    rdata = mem_rd;
    case (req_size)
      2'b00:   rdata = req_unsigned ? {24'h000000, byte_lane}
                                    : {{24{byte_lane[7]}}, byte_lane};
      2'b01:   rdata = req_unsigned ? {16'h0000, half_lane}
                                    : {{16{half_lane[15]}}, half_lane};
      default: rdata = mem_rd;          // word (and reserved size as word)
    endcase

    if (misaligned) begin
      rdata = 32'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Merge of the latched byte/half into the captured old word
  // ---------------------------------------------------------------------------
  always_comb begin
    merged = merge_q;
    if (half_q) begin
      if (lane_q[1]) begin
        merged[31:16] = data_q;
      end else begin
        merged[15:0] = data_q;
      end
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = data_q[7:0];
        2'd1:    merged[15:8]  = data_q[7:0];
        2'd2:    merged[23:16] = data_q[7:0];
        default: merged[31:24] = data_q[7:0];
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-side control. Outputs are combinational because a word store must
  // write, and a sub-word store must stall, in the cycle the request appears.
  // Reset gates every write and stall so that an RMW in flight is cancelled.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall     = 1'b0;
    mem_we    = 1'b0;
    mem_a     = {req_addr[31:2], 2'b00};
    mem_wd    = req_wdata;
    start_rmw = 1'b0;

    if (state == S_RMW) begin
      mem_a  = addr_q;
      mem_wd = merged;
      mem_we = ~reset;
    end else if (req_valid && req_we && !misaligned && !reset) begin
      if (req_size[1]) begin
        // Word store (size 10, or 11 treated as word): write-through.
        mem_we = 1'b1;
      end else begin
        stall     = 1'b1;
        start_rmw = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and capture registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= 32'h0;
      merge_q <= 32'h0;
      data_q  <= 16'h0;
      lane_q  <= 2'd0;
      half_q  <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      err_sticky <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_rmw) begin
            addr_q  <= {req_addr[31:2], 2'b00};
            merge_q <= mem_rd;
            data_q  <= req_wdata[15:0];
            lane_q  <= req_addr[1:0];
            half_q  <= (req_size == 2'b01);
            state   <= S_RMW;
          end
        end
        S_RMW: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
`ifdef LSU_MISALIGN_CHECK_EN
      // Requests are only taken in IDLE, so only flag there.
      if (state == S_IDLE && misaligned) begin
        err_sticky <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// -----------------------------------------------------------------------------
// tb_lsu_align: self-checking bench for lsu_align with a behavioural
// word-addressed memory (16 words, byte addresses 0x00..0x3F).
// -----------------------------------------------------------------------------
module tb_lsu_align;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        misaligned;
  logic        err_sticky;
  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        dbg_state;

  lsu_align dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rdata        (rdata),
    .stall        (stall),
    .misaligned   (misaligned),
    .err_sticky   (err_sticky),
    .mem_a        (mem_a),
    .mem_we       (mem_we),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd),
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Memory model with a preload port
  // ---------------------------------------------------------------------------
  logic [31:0] tb_mem [0:15];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = 4'd0;
  logic [31:0] pre_val = 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_a[5:2]] <= mem_wd;
    end else if (pre_en) begin
      tb_mem[pre_idx] <= pre_val;
    end
  end

  assign mem_rd = tb_mem[mem_a[5:2]];

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_v(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic observe(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got=%h exp=<empty queue>", tag, got);
    end else begin
      check(tag, got, exp_q.pop_front());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference models
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] size,
                                           input logic uns, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = w[16*off[1] +: 16];
    case (size)
      2'b00:   ref_load = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   ref_load = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: ref_load = w;
    endcase
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [1:0] size,
                                            input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (size == 2'b01) r[16*off[1] +: 16] = wd[15:0];
    else               r[8*off +: 8]      = wd[7:0];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge; outputs are
  // sampled 3 units later, well before the next rising edge)
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    idle();
    pre_idx = idx;
    pre_val = val;
    pre_en  = 1'b1;
    next_cycle();
    pre_en  = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, sz, uns, a, 32'hA5A5_A5A5);
    expect_v(exp);
    expect_v(32'd0);
    expect_v(32'd0);
    #3;
    observe(tag, rdata);
    observe({tag, "_stall"}, {31'd0, stall});
    observe({tag, "_we"}, {31'd0, mem_we});
    next_cycle();
  endtask

  // Two-cycle sub-word store; leaves the request driven so a caller can
  // chain another store with no idle cycle in between.
  task automatic do_sub_store(input string tag, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] exp_word);
    drive(1'b1, 1'b1, sz, 1'b0, a, wd);
    expect_v(32'd1);
    expect_v(32'd0);
    #3;
    observe({tag, "_c1_stall"}, {31'd0, stall});
    observe({tag, "_c1_we"}, {31'd0, mem_we});
    next_cycle();
    expect_v(32'd0);
    expect_v(32'd1);
    expect_v(exp_word);
    expect_v({a[31:2], 2'b00});
    #3;
    observe({tag, "_c2_stall"}, {31'd0, stall});
    observe({tag, "_c2_we"}, {31'd0, mem_we});
    observe({tag, "_c2_wd"}, mem_wd);
    observe({tag, "_c2_a"}, mem_a);
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] v;
    logic [31:0] old;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic        uns;

    reset = 1'b1;
    idle();
    next_cycle();

    // Reset holds off a sub-word store: no stall, no write.
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h22, 32'hAB);
    expect_v(32'd0);
    expect_v(32'd0);
    #3;
    observe("rst_stall", {31'd0, stall});
    observe("rst_we", {31'd0, mem_we});
    next_cycle();
    idle();
    next_cycle();
    reset = 1'b0;
    expect_v(32'd0);
    expect_v(32'd0);
    #3;
    observe("rst_err", {31'd0, err_sticky});
    observe("rst_state", {31'd0, dbg_state});
    next_cycle();

    // Load extension
    poke(4'd4, 32'h8081_F27F);
    do_load("lb_11",  2'b00, 1'b0, 32'h11, 32'hFFFF_FFF2);
    do_load("lbu_11", 2'b00, 1'b1, 32'h11, 32'h0000_00F2);
    do_load("lh_12",  2'b01, 1'b0, 32'h12, 32'hFFFF_8081);
    do_load("lhu_12", 2'b01, 1'b1, 32'h12, 32'h0000_8081);
    do_load("lw_10",  2'b10, 1'b0, 32'h10, 32'h8081_F27F);
    do_load("lb_13",  2'b00, 1'b0, 32'h13, 32'hFFFF_FF80);
    do_load("lbu_10", 2'b00, 1'b1, 32'h10, 32'h0000_007F);
    do_load("lh_10",  2'b01, 1'b0, 32'h10, 32'hFFFF_F27F);

    // Random aligned loads
    for (int i = 0; i < 10; i++) begin
      v   = $urandom;
      sz  = 2'($urandom_range(0, 2));
      uns = 1'($urandom_range(0, 1));
      off = 2'($urandom_range(0, 3));
      if (sz == 2'b01) off[0] = 1'b0;
      if (sz == 2'b10) off = 2'b00;
      poke(4'd5, v);
      do_load("rnd_ld", sz, uns, 32'h14 + {30'd0, off}, ref_load(v, sz, uns, off));
    end

    // Word store: write-through, no stall
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
    expect_v(32'd0);
    expect_v(32'd1);
    expect_v(32'hDEAD_BEEF);
    expect_v(32'h20);
    #3;
    observe("sw_stall", {31'd0, stall});
    observe("sw_we", {31'd0, mem_we});
    observe("sw_wd", mem_wd);
    observe("sw_a", mem_a);
    next_cycle();
    idle();
    expect_v(32'hDEAD_BEEF);
    observe("sw_mem", tb_mem[8]);

    // SB read-modify-write; upper wdata bits must be ignored
    poke(4'd8, 32'h1122_3344);
    do_sub_store("sb_22", 2'b00, 32'h22, 32'h1234_56AB, 32'h11AB_3344);
    idle();
    expect_v(32'h11AB_3344);
    observe("sb_mem", tb_mem[8]);

    // SH then SB back-to-back on the same word
    poke(4'd9, 32'h5566_7788);
    do_sub_store("sh_24", 2'b01, 32'h24, 32'h0000_BEEF, 32'h5566_BEEF);
    do_sub_store("sb_27", 2'b00, 32'h27, 32'h0000_0099, 32'h9966_BEEF);
    idle();
    expect_v(32'h9966_BEEF);
    observe("b2b_mem", tb_mem[9]);

    // Random sub-word stores
    for (int i = 0; i < 6; i++) begin
      old = $urandom;
      v   = $urandom;
      sz  = 2'($urandom_range(0, 1));
      off = 2'($urandom_range(0, 3));
      if (sz == 2'b01) off[0] = 1'b0;
      poke(4'd6, old);
      do_sub_store("rnd_st", sz, 32'h18 + {30'd0, off}, v, ref_merge(old, sz, off, v));
      idle();
      expect_v(ref_merge(old, sz, off, v));
      observe("rnd_st_mem", tb_mem[6]);
    end

    // Reset during RMW cancels the write
    poke(4'd10, 32'hCAFE_F00D);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h28, 32'h11);
    expect_v(32'd1);
    #3;
    observe("rstrmw_c1_stall", {31'd0, stall});
    next_cycle();
    reset = 1'b1;
    expect_v(32'd0);
    expect_v(32'd0);
    #3;
    observe("rstrmw_we", {31'd0, mem_we});
    observe("rstrmw_stall", {31'd0, stall});
    next_cycle();
    reset = 1'b0;
    idle();
    expect_v(32'd0);
    expect_v(32'hCAFE_F00D);
    #3;
    observe("rstrmw_state", {31'd0, dbg_state});
    observe("rstrmw_mem", tb_mem[10]);
    next_cycle();

    // Misaligned word store at 0x22 (word 8 currently 0x11AB3344)
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h22, 32'h0BAD_F00D);
`ifdef LSU_MISALIGN_CHECK_EN
    expect_v(32'd1);
    expect_v(32'd0);
    expect_v(32'd0);
    #3;
    observe("mis_sw_flag", {31'd0, misaligned});
    observe("mis_sw_we", {31'd0, mem_we});
    observe("mis_sw_stall", {31'd0, stall});
    next_cycle();
    idle();
    expect_v(32'd1);
    expect_v(32'h11AB_3344);
    #3;
    observe("mis_err_set", {31'd0, err_sticky});
    observe("mis_mem", tb_mem[8]);
    next_cycle();
    repeat (3) next_cycle();
    expect_v(32'd1);
    observe("mis_err_hold", {31'd0, err_sticky});
    // Misaligned load returns zero
    poke(4'd4, 32'h8081_F27F);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    expect_v(32'd0);
    expect_v(32'd1);
    #3;
    observe("mis_lh_rdata", rdata);
    observe("mis_lh_flag", {31'd0, misaligned});
    next_cycle();
    idle();
`else
    expect_v(32'd0);
    expect_v(32'd1);
    expect_v(32'h20);
    #3;
    observe("mis_sw_flag", {31'd0, misaligned});
    observe("mis_sw_we", {31'd0, mem_we});
    observe("mis_sw_a", mem_a);
    next_cycle();
    idle();
    expect_v(32'd0);
    expect_v(32'h0BAD_F00D);
    #3;
    observe("mis_err", {31'd0, err_sticky});
    observe("mis_mem", tb_mem[8]);
    next_cycle();
`endif

    // Reset clears the sticky error
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    expect_v(32'd0);
    #3;
    observe("final_err", {31'd0, err_sticky});
    next_cycle();

    if (exp_q.size() != 0) begin
      check("queue_drained", exp_q.size(), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
